// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl: line-follower steering controller.
// Raw active-low sensors are synchronised, inverted and debounced per bit;
// the debounced vector is decoded into a steering state that drives a
// registered {turn, mode} command on dir (mirrored on led).
// Optional feature: define LINE_STEER_SEARCH_EN to pivot toward the last
// known side when the line is lost, giving up to STOP after SEARCH_CYCLES.
//
// state    | meaning
// ---------+--------------------------------------------------------
// STOP   0 | halted (conflict, lost line, or reset)
// FOLLOW 1 | both centre sensors on line, drive straight
// VEER_L 2 | left centre only, gentle left (hard after HARD_CYCLES)
// VEER_R 3 | right centre only, gentle right (hard after HARD_CYCLES)
// TURN_L 4 | outer left seen, pivot left for at least CORNER_CYCLES
// TURN_R 5 | outer right seen, pivot right for at least CORNER_CYCLES
// SEARCH 6 | line lost, pivot toward last side (optional feature)
module line_steer_ctrl #(
    parameter int N_SENS        = 4,
    parameter int DEB_CYCLES    = 12_500_000,
    parameter int CORNER_CYCLES = 50_000_000,
    parameter int HARD_CYCLES   = 25_000_000,
    parameter int SEARCH_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] sens_n,
    output logic [3:0]        dir,
    output logic [3:0]        led,
    output logic [N_SENS-1:0] line,
    output logic [2:0]        state
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // One shared state timer, wide enough for the longest interval.
    localparam int T_A   = (CORNER_CYCLES > HARD_CYCLES) ? CORNER_CYCLES : HARD_CYCLES;
    localparam int T_MAX = (SEARCH_CYCLES > T_A) ? SEARCH_CYCLES : T_A;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] TMR_SAT     = '1;
    localparam logic [TW-1:0] HARD_LAST   = TW'(HARD_CYCLES - 1);
    localparam logic [TW-1:0] CORNER_LAST = TW'(CORNER_CYCLES - 1);
`ifdef LINE_STEER_SEARCH_EN
    localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_STOP   = 3'd0,
        S_FOLLOW = 3'd1,
        S_VEER_L = 3'd2,
        S_VEER_R = 3'd3,
        S_TURN_L = 3'd4,
        S_TURN_R = 3'd5
`ifdef LINE_STEER_SEARCH_EN
        , S_SEARCH = 3'd6
`endif
    } st_t;

    logic [N_SENS-1:0] sync1, sync2;
    logic [DW-1:0]     deb_cnt [N_SENS];
    logic [TW-1:0]     tmr;
    st_t               st, nxt, dec_st, lost_st;
    logic              cl, cr, ol, orr, lost;
    logic              veer_hard;
`ifdef LINE_STEER_SEARCH_EN
    logic              srch_r;
    logic              srch_side;
`endif

    // Two-flop synchroniser; inversion at the input so reset means "no line".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~sens_n;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: line flips after DEB_CYCLES consecutive disagreements.
    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
            for (int i = 0; i < N_SENS; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENS; i++) begin
                if (sync2[i] == line[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    line[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign cl   = line[N_SENS/2-1];
    assign cr   = line[N_SENS/2];
    assign ol   = |line[N_SENS/2-2:0];
    assign orr  = |line[N_SENS-1:N_SENS/2+1];
    assign lost = ~|line;

    // Priority decode of the debounced sensor groups (LOST handled apart).
    always_comb begin
        dec_st = S_STOP;
        if (ol && orr)     dec_st = S_STOP;
        else if (ol)       dec_st = S_TURN_L;
        else if (orr)      dec_st = S_TURN_R;
        else if (cl && cr) dec_st = S_FOLLOW;
        else if (cl)       dec_st = S_VEER_L;
        else if (cr)       dec_st = S_VEER_R;
    end

    // Where a lost line leads from the current state.
    always_comb begin
        lost_st = S_STOP;
`ifdef LINE_STEER_SEARCH_EN
        if (st == S_VEER_L || st == S_TURN_L || st == S_VEER_R || st == S_TURN_R)
            lost_st = S_SEARCH;
        else if (st == S_SEARCH)
            lost_st = S_SEARCH;
`endif
    end

    // Next-state selection.
    always_comb begin
        nxt = st;
        case (st)
            S_STOP:
                if (!lost && dec_st != S_STOP) nxt = dec_st;
            S_FOLLOW, S_VEER_L, S_VEER_R:
                nxt = lost ? lost_st : dec_st;
            S_TURN_L, S_TURN_R:
                if (tmr >= CORNER_LAST) begin
                    if (lost)                    nxt = lost_st;
                    else if (dec_st == S_STOP)   nxt = S_STOP;
                    else if (dec_st == S_FOLLOW) nxt = S_FOLLOW;
                end
`ifdef LINE_STEER_SEARCH_EN
            S_SEARCH:
                if (!lost)                    nxt = dec_st;
                else if (tmr >= SEARCH_LAST)  nxt = S_STOP;
`endif
            default:
                nxt = S_STOP;
        endcase
    end

    assign veer_hard = (nxt == st) && (tmr >= HARD_LAST);

`ifdef LINE_STEER_SEARCH_EN
    // Side to pivot while searching: captured on entry, held afterwards.
    assign srch_side = (nxt == S_SEARCH && st != S_SEARCH) ?
                       (st == S_VEER_R || st == S_TURN_R) : srch_r;
`endif

    // State, timer and registered steering command.
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= S_STOP;
            tmr <= '0;
            dir <= 4'b1111;
`ifdef LINE_STEER_SEARCH_EN
            srch_r <= 1'b0;
`endif
        end else begin
            st <= nxt;
            if (nxt != st)         tmr <= '0;
            else if (tmr != TMR_SAT) tmr <= tmr + TW'(1);
`ifdef LINE_STEER_SEARCH_EN
            srch_r <= srch_side;
`endif
            case (nxt)
                S_FOLLOW: dir <= 4'b0000;
                S_VEER_L: dir <= {2'b01, veer_hard ? 2'b10 : 2'b01};
                S_VEER_R: dir <= {2'b10, veer_hard ? 2'b10 : 2'b01};
                S_TURN_L: dir <= 4'b0111;
                S_TURN_R: dir <= 4'b1011;
`ifdef LINE_STEER_SEARCH_EN
                S_SEARCH: dir <= {srch_side ? 2'b10 : 2'b01, 2'b11};
`endif
                default:  dir <= 4'b1111;
            endcase
        end
    end

    assign led   = dir;
    assign state = st;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Scoreboard bench for line_steer_ctrl: each scenario task pushes expected
// {dir, state, line} at given cycle offsets and compares as the run reaches them.
module tb_line_steer_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sens_n = 4'b1111;
    logic [3:0]   dir, led;
    logic [N-1:0] line;
    logic [2:0]   state;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] dir;
        logic [2:0] st;
        logic [3:0] line;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    line_steer_ctrl #(
        .N_SENS(4), .DEB_CYCLES(4), .CORNER_CYCLES(16),
        .HARD_CYCLES(8), .SEARCH_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .sens_n(sens_n),
        .dir(dir), .led(led), .line(line), .state(state)
    );

    always #5 clk = ~clk;

    task automatic want(input int at, input string nm, input logic [3:0] d,
                        input logic [2:0] s, input logic [3:0] l);
        exp_t x;
        x.at = at; x.name = nm; x.dir = d; x.st = s; x.line = l;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1; sens_n = 4'b1111;
        want(1, "rst_c1", 4'b1111, 3'd0, 4'b0000);
        want(3, "rst_c3", 4'b1111, 3'd0, 4'b0000);
        want(6, "rst_idle", 4'b1111, 3'd0, 4'b0000);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 3) rst = 1'b0;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_follow_glitch();
        sens_n = 4'b1001;
        want(5, "deb_pending", 4'b1111, 3'd0, 4'b0000);
        want(6, "line_up", 4'b1111, 3'd0, 4'b0110);
        want(7, "follow_entry", 4'b0000, 3'd1, 4'b0110);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
        end
        sens_n = 4'b1000;
        want(4, "glitch_mid", 4'b0000, 3'd1, 4'b0110);
        want(7, "glitch_end", 4'b0000, 3'd1, 4'b0110);
        want(10, "glitch_after", 4'b0000, 3'd1, 4'b0110);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 3) sens_n = 4'b1001;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL follow: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_veer();
        sens_n = 4'b1101;
        want(6, "veer_line", 4'b0000, 3'd1, 4'b0010);
        want(7, "veer_entry", 4'b0101, 3'd2, 4'b0010);
        want(14, "veer_pre_hard", 4'b0101, 3'd2, 4'b0010);
        want(15, "veer_hard", 4'b0110, 3'd2, 4'b0010);
        want(20, "veer_hard_hold", 4'b0110, 3'd2, 4'b0010);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL veer: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_turn();
        sens_n = 4'b1110;
        want(6, "turn_line", 4'b0110, 3'd2, 4'b0001);
        want(7, "turn_entry", 4'b0111, 3'd4, 4'b0001);
        want(10, "turn_ignore_cc", 4'b0111, 3'd4, 4'b0110);
        want(22, "turn_hold_end", 4'b0111, 3'd4, 4'b0110);
        want(23, "turn_exit", 4'b0000, 3'd1, 4'b0110);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 4) sens_n = 4'b1001;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL turn: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_turn_reverse();
        sens_n = 4'b1110;
        want(7, "rev_entry", 4'b0111, 3'd4, 4'b0001);
        want(11, "rev_req_ignored", 4'b0111, 3'd4, 4'b1000);
        want(24, "rev_after_hold", 4'b0111, 3'd4, 4'b1000);
        want(30, "rev_line", 4'b0111, 3'd4, 4'b0110);
        want(31, "rev_exit", 4'b0000, 3'd1, 4'b0110);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 4)  sens_n = 4'b0111;
            if (k == 24) sens_n = 4'b1001;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL turn_reverse: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_stop();
        sens_n = 4'b0110;
        want(6, "stop_line", 4'b0000, 3'd1, 4'b1001);
        want(7, "stop_entry", 4'b1111, 3'd0, 4'b1001);
        want(14, "stop_line_cc", 4'b1111, 3'd0, 4'b0110);
        want(15, "stop_exit", 4'b0000, 3'd1, 4'b0110);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 8) sens_n = 4'b1001;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL stop: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_lost();
        sens_n = 4'b1011;
        want(7, "veer_r_entry", 4'b1001, 3'd3, 4'b0100);
        want(14, "lost_line", 4'b1001, 3'd3, 4'b0000);
`ifdef LINE_STEER_SEARCH_EN
        want(15, "search_entry", 4'b1011, 3'd6, 4'b0000);
        want(34, "search_hold", 4'b1011, 3'd6, 4'b0000);
        want(35, "search_timeout", 4'b1111, 3'd0, 4'b0000);
`else
        want(15, "lost_stop", 4'b1111, 3'd0, 4'b0000);
`endif
        want(40, "stop_while_lost", 4'b1111, 3'd0, 4'b0000);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 8) sens_n = 4'b1111;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL lost: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        sens_n = 4'b1001;
        want(4, "rst_mid_deb", 4'b1111, 3'd0, 4'b0000);
        want(10, "rst_deb_restart", 4'b1111, 3'd0, 4'b0000);
        want(11, "rst_mid_line", 4'b1111, 3'd0, 4'b0110);
        want(12, "rst_mid_follow", 4'b0000, 3'd1, 4'b0110);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 3) rst = 1'b1;
            if (k == 5) rst = 1'b0;
        end
        sens_n = 4'b1110;
        want(7, "rst_turn_entry", 4'b0111, 3'd4, 4'b0001);
        want(10, "rst_mid_turn", 4'b1111, 3'd0, 4'b0000);
        want(16, "rst_turn_line", 4'b1111, 3'd0, 4'b0001);
        want(17, "rst_turn_reentry", 4'b0111, 3'd4, 4'b0001);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at == k) begin
                e = exp_q.pop_front(); n_chk++;
                if (dir !== e.dir || led !== e.dir || state !== e.st || line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got dir=%b led=%b state=%0d line=%b, want dir=%b state=%0d line=%b",
                             e.name, k, dir, led, state, line, e.dir, e.st, e.line);
                end
            end
            if (k == 9)  rst = 1'b1;
            if (k == 10) rst = 1'b0;
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_mid: %0d expectations not reached", exp_q.size()); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_follow_glitch();
        test_veer();
        test_turn();
        test_turn_reverse();
        test_stop();
        test_lost();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
